stage_writeback: RTL and testbench

Final pipeline stage of the CPU core: consumes the operation, datum and registered data pointer produced by the execute stage. Commits modified datums to DRAM and drives the EXT output channel. Resolves loop branch conditions and reports them to the fetch side. It is the only pipeline stage that can stall on the output channel; it back-pressures execute through `ack`.

---
 rtl/stage_writeback.sv | 154 +++++++++++++++
 tb/tb_stage_writeback.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stage_writeback.sv
// stage_writeback: last CPU pipeline stage. It commits modified datums to DRAM, drives the EXT output byte channel and resolves loop branch conditions for fetch.
// Latency: accept, DRAM commit and the unbuffered EXT byte are combinational in the accept cycle; loop pulses and FIFO-buffered bytes appear 1 cycle after accept.
// Backpressure: only OP_OUT can stall (ack=0), while the EXT sink is not ready or, in buffered builds, while the output FIFO is full and the sink is not ready.
//
// Optional feature: define WRITEBACK_OUT_FIFO_EN to add a FIFO_DEPTH-entry output byte FIFO.
//
// Ports:
//   clk, reset          single clock; synchronous active-low reset
//   operation_in        one-hot op from execute (all-zero = bubble)
//   a_in, dp_in         datum and registered data pointer from execute
//   ack                 operation accepted this cycle (execute's ack_in)
//   dwe, dwa, dwd       DRAM write port, committed in the accept cycle
//   cout_d, cout_wr     EXT output byte / valid
//   cout_rdy            EXT sink ready; transfer when cout_wr && cout_rdy
//   loop_skip           1-cycle pulse: accepted LOOPBEGIN saw datum 0
//   loop_back           1-cycle pulse: accepted LOOPEND saw non-zero datum
module stage_writeback #(
    parameter int A_WIDTH    = 12,
    parameter int D_WIDTH    = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int OPCODE_MSB = 7
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [OPCODE_MSB:0]   operation_in,
    input  logic [D_WIDTH-1:0]    a_in,
    input  logic [A_WIDTH-1:0]    dp_in,
    output logic                  ack,
    output logic                  dwe,
    output logic [A_WIDTH-1:0]    dwa,
    output logic [D_WIDTH-1:0]    dwd,
    output logic [7:0]            cout_d,
    output logic                  cout_wr,
    input  logic                  cout_rdy,
    output logic                  loop_skip,
    output logic                  loop_back
);

    // One-hot opcode bit positions shared with the execute stage.
    localparam int OP_INCDP     = 0;
    localparam int OP_DECDP     = 1;
    localparam int OP_INC       = 2;
    localparam int OP_DEC       = 3;
    localparam int OP_OUT       = 4;
    localparam int OP_IN        = 5;
    localparam int OP_LOOPBEGIN = 6;
    localparam int OP_LOOPEND   = 7;

    logic       is_out;
    logic       is_wr;
    logic       stall;
    logic [7:0] out_byte;

    assign is_out = operation_in[OP_OUT];
    assign is_wr  = operation_in[OP_INC] | operation_in[OP_DEC] | operation_in[OP_IN];

    // Pointer moves (INCDP/DECDP) are resolved upstream; here they behave as bubbles.
    // Gating with reset keeps ack (and with it every side effect) low during reset.
    assign ack = reset && !stall;

    // Commit in the accept cycle so DRAM is up to date at the same edge that
    // execute's forwarding register retires the value.
    assign dwe = ack && is_wr;
    assign dwa = dp_in;
    assign dwd = a_in;

    generate
        if (D_WIDTH >= 8) begin : g_byte_trunc
            assign out_byte = a_in[7:0];
        end else begin : g_byte_zext
            assign out_byte = {{(8 - D_WIDTH){1'b0}}, a_in};
        end
    endgenerate

    // Loop resolution, registered: one-cycle pulses after the accept edge.
    logic loop_skip_q, loop_skip_d;
    logic loop_back_q, loop_back_d;

    always_comb begin
        loop_skip_d = ack && operation_in[OP_LOOPBEGIN] && (a_in == '0);
        loop_back_d = ack && operation_in[OP_LOOPEND]   && (a_in != '0);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            loop_skip_q <= 1'b0;
            loop_back_q <= 1'b0;
        end else begin
            loop_skip_q <= loop_skip_d;
            loop_back_q <= loop_back_d;
        end
    end

    assign loop_skip = loop_skip_q;
    assign loop_back = loop_back_q;

`ifdef WRITEBACK_OUT_FIFO_EN
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full;
    logic             push;
    logic             pop;

    assign full = (count_q == FULL_CNT);

    // A full FIFO still accepts when the sink drains the head in the same
    // cycle: the head is read before the edge that overwrites its slot.
    assign stall = is_out && full && !cout_rdy;
    assign push  = ack && is_out;

    // Gated by reset so nothing leaks to the sink while buffered bytes are being discarded.
    assign cout_wr = reset && (count_q != '0);
    assign cout_d  = cout_wr ? mem_q[rd_ptr_q] : 8'h00;
    assign pop     = cout_wr && cout_rdy;

    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the count alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= out_byte;
        end
    end
`else
    // Unbuffered: the byte goes straight to the sink; OP_OUT waits for cout_rdy
    // and the transfer coincides with the accept edge.
    assign stall   = is_out && !cout_rdy;
    assign cout_wr = reset && is_out;
    assign cout_d  = reset ? out_byte : 8'h00;
`endif

endmodule

// File: tb/tb_stage_writeback.sv
module tb_stage_writeback;
    localparam int A_WIDTH    = 12;
    localparam int D_WIDTH    = 8;
    localparam int FIFO_DEPTH = 4;
    localparam int OPCODE_MSB = 7;

    localparam int OP_INCDP     = 0;
    localparam int OP_DECDP     = 1;
    localparam int OP_INC       = 2;
    localparam int OP_DEC       = 3;
    localparam int OP_OUT       = 4;
    localparam int OP_IN        = 5;
    localparam int OP_LOOPBEGIN = 6;
    localparam int OP_LOOPEND   = 7;
    localparam int BUBBLE       = -1;

    logic                clk = 1'b0;
    logic                reset;
    logic [OPCODE_MSB:0] operation_in;
    logic [D_WIDTH-1:0]  a_in;
    logic [A_WIDTH-1:0]  dp_in;
    logic                ack;
    logic                dwe;
    logic [A_WIDTH-1:0]  dwa;
    logic [D_WIDTH-1:0]  dwd;
    logic [7:0]          cout_d;
    logic                cout_wr;
    logic                cout_rdy;
    logic                loop_skip;
    logic                loop_back;

    always #5 clk = ~clk;

    stage_writeback #(
        .A_WIDTH(A_WIDTH), .D_WIDTH(D_WIDTH),
        .FIFO_DEPTH(FIFO_DEPTH), .OPCODE_MSB(OPCODE_MSB)
    ) dut (
        .clk(clk), .reset(reset), .operation_in(operation_in),
        .a_in(a_in), .dp_in(dp_in), .ack(ack),
        .dwe(dwe), .dwa(dwa), .dwd(dwd),
        .cout_d(cout_d), .cout_wr(cout_wr), .cout_rdy(cout_rdy),
        .loop_skip(loop_skip), .loop_back(loop_back)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit rdy_rand = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Expected-response queues, filled by the driver when an op is issued.
    typedef struct packed { logic [A_WIDTH-1:0] addr; logic [D_WIDTH-1:0] data; } wr_t;
    typedef struct { bit back; int at; } pulse_t;
    wr_t        wr_q[$];
    logic [7:0] byte_q[$];
    pulse_t     pulse_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [OPCODE_MSB:0] onehot(input int op);
        logic [OPCODE_MSB:0] v;
        v = '0;
        if (op >= 0) v[op] = 1'b1;
        return v;
    endfunction

    // Reference model: the architectural effect of each op, independent of timing.
    task automatic present(input int op, input logic [7:0] a, input logic [A_WIDTH-1:0] dp);
        wr_t    w;
        pulse_t p;
        operation_in = onehot(op);
        a_in         = a;
        dp_in        = dp;
        if (op == OP_INC || op == OP_DEC || op == OP_IN) begin
            w.addr = dp;
            w.data = a;
            wr_q.push_back(w);
        end
        if (op == OP_OUT) byte_q.push_back(a);
        // Loop ops never stall, so they retire at the next edge and pulse the cycle after.
        if (op == OP_LOOPBEGIN && a == 0) begin
            p.back = 1'b0; p.at = cyc + 1; pulse_q.push_back(p);
        end
        if (op == OP_LOOPEND && a != 0) begin
            p.back = 1'b1; p.at = cyc + 1; pulse_q.push_back(p);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Random sink readiness, changed away from the edge.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (rdy_rand) cout_rdy = ($urandom_range(0, 9) < 7);
        end
    end

    // Monitor: pops expectations whenever the DUT presents a response.
    initial begin
        bit         prev_hold;
        logic [7:0] prev_d;
        wr_t        w;
        pulse_t     p;
        prev_hold = 1'b0;
        prev_d    = 8'h00;
        forever begin
            @(negedge clk);
            if (reset === 1'b1) begin
                if (dwe) begin
                    check("dram_write_expected", wr_q.size() != 0, 1);
                    if (wr_q.size() != 0) begin
                        w = wr_q.pop_front();
                        check("dram_addr", dwa, w.addr);
                        check("dram_data", dwd, w.data);
                    end
                end
                if (cout_wr && cout_rdy) begin
                    check("cout_byte_expected", byte_q.size() != 0, 1);
                    if (byte_q.size() != 0) check("cout_byte", cout_d, byte_q.pop_front());
                end
                if (loop_skip || loop_back) begin
                    check("pulse_expected", pulse_q.size() != 0, 1);
                    if (pulse_q.size() != 0) begin
                        p = pulse_q.pop_front();
                        check("pulse_kind_back", loop_back, p.back);
                        check("pulse_kind_skip", loop_skip, !p.back);
                        check("pulse_cycle", cyc, p.at);
                    end
                end
                if (pulse_q.size() != 0 && pulse_q[0].at < cyc) begin
                    check("pulse_missed_at", cyc, pulse_q[0].at);
                    void'(pulse_q.pop_front());
                end
                if (prev_hold) begin
                    check("cout_hold_wr", cout_wr, 1);
                    check("cout_hold_d", cout_d, prev_d);
                end
`ifndef WRITEBACK_OUT_FIFO_EN
                check("ack_rule", ack, !(operation_in[OP_OUT] && !cout_rdy));
                check("cout_wr_rule", cout_wr, operation_in[OP_OUT]);
`endif
                prev_hold = cout_wr && !cout_rdy;
                prev_d    = cout_d;
            end else begin
                prev_hold = 1'b0;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int op;
        // ---- reset with OP_INC presented ----
        reset        = 1'b0;
        operation_in = onehot(OP_INC);
        a_in         = 8'h11;
        dp_in        = 12'h005;
        cout_rdy     = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("rst_ack", ack, 0);
            check("rst_dwe", dwe, 0);
            check("rst_cout_wr", cout_wr, 0);
            check("rst_cout_d", cout_d, 0);
            check("rst_loop_skip", loop_skip, 0);
            check("rst_loop_back", loop_back, 0);
        end
        step();
        reset = 1'b1;
        present(OP_INC, 8'h11, 12'h005);
        @(negedge clk);
        check("rel_ack", ack, 1);
        check("rel_dwe", dwe, 1);
        step();

        // ---- DRAM commit ----
        present(OP_INC, 8'h42, 12'h123);
        @(negedge clk);
        check("commit_dwe", dwe, 1);
        check("commit_dwa", dwa, 12'h123);
        check("commit_dwd", dwd, 8'h42);
        check("commit_ack", ack, 1);
        step();
        present(BUBBLE, 8'h00, 12'h000);
        @(negedge clk);
        check("bubble_dwe", dwe, 0);
        step();

        // ---- loops ----
        present(OP_LOOPBEGIN, 8'h00, 12'h010);
        @(negedge clk);
        check("lb_ack", ack, 1);
        check("lb_dwe", dwe, 0);
        step();
        present(BUBBLE, 8'h00, 12'h000);
        @(negedge clk);
        check("lb_skip_pulse", loop_skip, 1);
        check("lb_no_back", loop_back, 0);
        step();
        @(negedge clk);
        check("lb_skip_single", loop_skip, 0);
        step();
        present(OP_LOOPEND, 8'h05, 12'h011);
        @(negedge clk);
        check("le_dwe", dwe, 0);
        step();
        present(BUBBLE, 8'h00, 12'h000);
        @(negedge clk);
        check("le_back_pulse", loop_back, 1);
        step();
        @(negedge clk);
        check("le_back_single", loop_back, 0);
        step();
        present(OP_LOOPEND, 8'h00, 12'h012);
        @(negedge clk);
        check("le0_dwe", dwe, 0);
        step();
        present(BUBBLE, 8'h00, 12'h000);
        @(negedge clk);
        check("le0_no_back", loop_back, 0);
        check("le0_no_skip", loop_skip, 0);
        step();

`ifndef WRITEBACK_OUT_FIFO_EN
        // ---- unbuffered OP_OUT stall ----
        cout_rdy = 1'b0;
        present(OP_OUT, 8'h41, 12'h000);
        repeat (3) begin
            @(negedge clk);
            check("out_stall_ack", ack, 0);
            check("out_stall_wr", cout_wr, 1);
            check("out_stall_d", cout_d, 8'h41);
            step();
        end
        cout_rdy = 1'b1;
        @(negedge clk);
        check("out_go_ack", ack, 1);
        check("out_go_wr", cout_wr, 1);
        step();
        cout_rdy = 1'b0;
        present(OP_INC, 8'h07, 12'h020);
        @(negedge clk);
        check("inc_after_out_ack", ack, 1);
        check("inc_after_out_dwe", dwe, 1);
        step();
        present(BUBBLE, 8'h00, 12'h000);
`else
        // ---- FIFO fill, full stall, simultaneous push/pop, drain ----
        cout_rdy = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            present(OP_OUT, 8'(i), 12'h000);
            @(negedge clk);
            check("fifo_fill_ack", ack, 1);
            step();
        end
        present(OP_OUT, 8'h05, 12'h000);
        @(negedge clk);
        check("fifo_full_ack", ack, 0);
        check("fifo_full_wr", cout_wr, 1);
        check("fifo_full_head", cout_d, 8'h01);
        step();
        cout_rdy = 1'b1;
        @(negedge clk);
        check("fifo_pushpop_ack", ack, 1);
        step();
        present(OP_INC, 8'h07, 12'h020);
        @(negedge clk);
        check("inc_after_out_ack", ack, 1);
        step();
        present(BUBBLE, 8'h00, 12'h000);
        n = 0;
        while (byte_q.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        step();
        @(negedge clk);
        check("fifo_drained", byte_q.size(), 0);
        check("fifo_empty_wr", cout_wr, 0);
        step();

        // ---- reset discards buffered bytes ----
        cout_rdy = 1'b0;
        present(OP_OUT, 8'hA1, 12'h000);
        step();
        present(OP_OUT, 8'hA2, 12'h000);
        step();
        present(BUBBLE, 8'h00, 12'h000);
        @(negedge clk);
        check("fifo_buffered_wr", cout_wr, 1);
        step();
        reset = 1'b0;
        byte_q.delete();
        step();
        reset    = 1'b1;
        cout_rdy = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("fifo_rst_discard_wr", cout_wr, 0);
            step();
        end
`endif

        // ---- randomized traffic ----
        rdy_rand = 1'b1;
        for (int k = 0; k < 500; k++) begin
            op = int'($urandom_range(0, 8)) - 1;
            present(op, ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom),
                    12'($urandom));
            n = 0;
            @(negedge clk);
            while (!ack && n < 64) begin
                n++;
                @(negedge clk);
            end
            check("rand_accept_bound", ack, 1);
            step();
        end
        present(BUBBLE, 8'h00, 12'h000);
        rdy_rand = 1'b0;
        cout_rdy = 1'b1;
        n = 0;
        while (byte_q.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        repeat (3) step();
        check("end_wr_q_empty", wr_q.size(), 0);
        check("end_byte_q_empty", byte_q.size(), 0);
        check("end_pulse_q_empty", pulse_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
